// File: rtl/seg_display_mux.sv
// Samples a 4-bit bouncing counter, shows it as two multiplexed decimal digits on a
// common-anode 7-segment display, and tracks direction/reversals. Define DIR_DP_EN to add the dp port.
module seg_display_mux #(
   parameter int REFRESH_W   = 16,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 en,
   input  logic [3:0]           valor,
   output logic [6:0]           seg,
   output logic [1:0]           an,
   output logic                 dir,
   output logic [7:0]           peak_cnt
`ifdef DIR_DP_EN
   ,
   output logic                 dp
`endif
);

   localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

   logic [3:0]           valor_q;
   logic [REFRESH_W-1:0] refresh_cnt;
   logic                 refresh_wrap;
   logic                 digit_sel;
   logic                 new_dir;
   logic                 reverse;
   logic                 tens;
   logic [3:0]           ones;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'h40;
         4'd1:    seg_code = 7'h79;
         4'd2:    seg_code = 7'h24;
         4'd3:    seg_code = 7'h30;
         4'd4:    seg_code = 7'h19;
         4'd5:    seg_code = 7'h12;
         4'd6:    seg_code = 7'h02;
         4'd7:    seg_code = 7'h78;
         4'd8:    seg_code = 7'h00;
         4'd9:    seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   // Equal samples keep the previous direction, so new_dir defaults to dir.
   always_comb begin
      new_dir = dir;
      if (valor > valor_q)
         new_dir = 1'b0;
      else if (valor < valor_q)
         new_dir = 1'b1;
      reverse = en && (new_dir != dir);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         valor_q  <= 4'd0;
         dir      <= 1'b0;
         peak_cnt <= 8'd0;
      end else if (en) begin
         valor_q <= valor;
         if (reverse) begin
            dir <= new_dir;
            if (peak_cnt != 8'hFF)
               peak_cnt <= peak_cnt + 8'd1;
         end
      end
   end

   assign refresh_wrap = (refresh_cnt == REFRESH_LAST);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         refresh_cnt <= '0;
         digit_sel   <= 1'b0;
      end else if (refresh_wrap) begin
         refresh_cnt <= '0;
         digit_sel   <= ~digit_sel;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   always_comb begin
      tens = (valor_q >= 4'd10);
      ones = tens ? (valor_q - 4'd10) : valor_q;
   end

   // A zero tens digit is blanked but its anode still cycles so the refresh duty stays even.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         an  <= 2'b11;
         seg <= 7'h7F;
      end else if (!digit_sel) begin
         an  <= 2'b10;
         seg <= seg_code(ones);
      end else begin
         an  <= 2'b01;
         seg <= tens ? seg_code(4'd1) : 7'h7F;
      end
   end

`ifdef DIR_DP_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         dp <= 1'b1;
      else
         dp <= ~(~digit_sel & dir);
   end
`endif

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: stimulus queues expected states, a monitor checks them.
// Build with DIR_DP_EN defined to also check the dp output.
module tb_seg_display_mux;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       en;
   logic [3:0] valor;
   logic [6:0] seg;
   logic [1:0] an;
   logic       dir;
   logic [7:0] peak_cnt;
`ifdef DIR_DP_EN
   logic       dp;
`endif

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int idx;

   typedef struct {
      int           at;
      logic [127:0] name;
      bit           chkDisp;
      logic [1:0]   an;
      logic [6:0]   seg;
      bit           chkStat;
      logic         dir;
      logic [7:0]   pk;
      bit           chkDp;
      logic         dp;
   } expT;

   expT  sb[$];
   event immEv;

   logic [3:0] eqVals [5] = '{4'd5, 4'd5, 4'd5, 4'd4, 4'd4};
   logic       eqDir  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0] eqPk   [5] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3};

   seg_display_mux #(
      .REFRESH_W   (16),
      .REFRESH_DIV (4)
   ) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .en       (en),
      .valor    (valor),
      .seg      (seg),
      .an       (an),
      .dir      (dir),
      .peak_cnt (peak_cnt)
`ifdef DIR_DP_EN
      ,
      .dp       (dp)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit e, input logic [3:0] v);
      en    = e;
      valor = v;
   endtask

   task automatic checkOutput(input logic [127:0] nm, input string field,
                              input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %0s.%0s at cycle %0d: got %0h, expected %0h", nm, field, cyc, got, want);
      end
   endtask

   task automatic expectAt(input int at, input logic [127:0] nm,
                           input bit cd, input logic [1:0] a, input logic [6:0] s,
                           input bit cs, input logic d, input logic [7:0] p,
                           input bit cdp, input logic dpv);
      expT e;
      e.at = at; e.name = nm;
      e.chkDisp = cd; e.an = a; e.seg = s;
      e.chkStat = cs; e.dir = d; e.pk = p;
      e.chkDp = cdp; e.dp = dpv;
      sb.push_back(e);
   endtask

   task automatic expectDisp(input int at, input logic [127:0] nm, input logic [1:0] a, input logic [6:0] s);
      expectAt(at, nm, 1'b1, a, s, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic expectStat(input int at, input logic [127:0] nm, input logic d, input logic [7:0] p);
      expectAt(at, nm, 1'b0, 2'b00, 7'h00, 1'b1, d, p, 1'b0, 1'b1);
   endtask

   task automatic compareEntry(input expT e);
      if (e.chkDisp) begin
         checkOutput(e.name, "an", 32'(an), 32'(e.an));
         checkOutput(e.name, "seg", 32'(seg), 32'(e.seg));
      end
      if (e.chkStat) begin
         checkOutput(e.name, "dir", 32'(dir), 32'(e.dir));
         checkOutput(e.name, "peak_cnt", 32'(peak_cnt), 32'(e.pk));
      end
`ifdef DIR_DP_EN
      if (e.chkDp)
         checkOutput(e.name, "dp", 32'(dp), 32'(e.dp));
`endif
   endtask

   task automatic finishTest();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   endtask

   // Monitor: entries due this cycle (or flagged immediate) are compared and retired.
   initial begin
      forever begin
         @(negedge clk or immEv);
         idx = 0;
         while (idx < sb.size()) begin
            if (sb[idx].at == -1 || sb[idx].at == cyc) begin
               compareEntry(sb[idx]);
               sb.delete(idx);
            end else if (sb[idx].at < cyc) begin
               checks++;
               failures++;
               $display("[TB] FAIL %0s missed: due cycle %0d, now %0d", sb[idx].name, sb[idx].at, cyc);
               sb.delete(idx);
            end else begin
               idx++;
            end
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      finishTest();
   end

   initial begin
      int r;
      int r2;
      logic [3:0] v;

      clr_n = 1'b0;
      applyStimulus(1'b0, 4'd0);
      tick();
      tick();
      expectAt(-1, "rst_init", 1'b1, 2'b11, 7'h7F, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
      ->immEv;

      // Release and watch the idle refresh pattern with value 0.
      clr_n = 1'b1;
      r = cyc;
      expectAt(r + 1, "first_edge", 1'b1, 2'b10, 7'h40, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
      expectDisp(r + 4, "ones_slot_end", 2'b10, 7'h40);
      expectDisp(r + 5, "tens_blank", 2'b01, 7'h7F);
      expectDisp(r + 8, "tens_blank_end", 2'b01, 7'h7F);
      expectDisp(r + 9, "ones_again", 2'b10, 7'h40);
      repeat (12) tick();

      // Sample 13 during a tens slot, then ignore input while en is low.
      applyStimulus(1'b1, 4'd13);
      tick();
      applyStimulus(1'b0, 4'd7);
      expectAt(r + 13, "lat_old_tens", 1'b1, 2'b01, 7'h7F, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
      expectDisp(r + 14, "tens_one", 2'b01, 7'h79);
      expectDisp(r + 17, "ones_three", 2'b10, 7'h30);
      expectDisp(r + 20, "ones_three_hold", 2'b10, 7'h30);
      repeat (7) tick();

      // 13 -> 12 is the first reversal.
      applyStimulus(1'b1, 4'd12);
      tick();
      applyStimulus(1'b0, 4'd12);
      expectStat(r + 21, "down_13_12", 1'b1, 8'd1);
      expectAt(r + 22, "tens_dp_off", 1'b1, 2'b01, 7'h79, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
      expectAt(r + 25, "ones_two_dp_on", 1'b1, 2'b10, 7'h24, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
      repeat (5) tick();

      // Asynchronous reset in the middle of the ones slot.
      clr_n = 1'b0;
      #1;
      expectAt(-1, "rst_async", 1'b1, 2'b11, 7'h7F, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
      ->immEv;
      tick();
      tick();
      clr_n = 1'b1;
      r2 = cyc;

      // Bouncing sequence 0..15, 14..0, 1.
      for (int i = 0; i < 32; i++) begin
         v = (i <= 15) ? 4'(i) : ((i <= 30) ? 4'(30 - i) : 4'd1);
         applyStimulus(1'b1, v);
         if (i == 15) expectStat(cyc + 1, "bounce_top", 1'b0, 8'd0);
         if (i == 16) expectStat(cyc + 1, "bounce_turn_dn", 1'b1, 8'd1);
         if (i == 30) expectStat(cyc + 1, "bounce_bottom", 1'b1, 8'd1);
         if (i == 31) expectStat(cyc + 1, "bounce_turn_up", 1'b0, 8'd2);
         tick();
      end
      if (cyc != r2 + 32) begin
         checks++;
         failures++;
         $display("[TB] FAIL bounce_timing: got cycle %0d, expected %0d", cyc, r2 + 32);
      end

      // Equal samples hold direction.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, eqVals[i]);
         expectStat(cyc + 1, "equal_hold", eqDir[i], eqPk[i]);
         tick();
      end

      // Alternate 3/4 until the reversal counter saturates.
      for (int j = 0; j < 300; j++) begin
         applyStimulus(1'b1, (j % 2 == 0) ? 4'd3 : 4'd4);
         if (j == 0)   expectStat(cyc + 1, "sat_first", 1'b1, 8'd3);
         if (j == 251) expectStat(cyc + 1, "sat_254", 1'b0, 8'd254);
         if (j == 252) expectStat(cyc + 1, "sat_255", 1'b1, 8'd255);
         if (j == 253) expectStat(cyc + 1, "sat_hold", 1'b0, 8'd255);
         if (j == 299) expectStat(cyc + 1, "sat_final", 1'b0, 8'd255);
         tick();
      end
      applyStimulus(1'b0, 4'd0);
      repeat (4) tick();

      while (sb.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %0s never checked: due cycle %0d", sb[0].name, sb[0].at);
         void'(sb.pop_front());
      end
      finishTest();
   end

endmodule
